i2s_src: RTL and testbench
==========================

I2S_SRC -- requirements
Module: i2s_src

Interface
REQ-001 Parameters (name, default, meaning): AUDIO_DW, 8, sample width in bits; legal range AUDIO_DW >= 2.
REQ-002 Parameters (name, default, meaning): CLK_DIV, 2, clk_i cycles per sck half-period; legal range CLK_DIV >= 1.
REQ-003 Parameters (name, default, meaning): SLOT_W, 16, sck periods per channel slot; legal range SLOT_W >= AUDIO_DW.
REQ-004 Ports (name, direction, width, meaning) SHALL be:
  clk_i  in  1  system clock; one clock domain only
  rst_ni  in  1  asynchronous, active-low reset
  en_i  in  1  serial clock generation enable
  s_l_data_i  in  AUDIO_DW  left sample to push
  s_r_data_i  in  AUDIO_DW  right sample to push
  s_valid_i  in  1  stereo frame valid
  s_ready_o  out  1  frame accepted when s_valid_i and s_ready_o are both high on a clk_i rising edge
  sck_o  out  1  I2S bit clock
  ws_o  out  1  word select; 0 = left slot, 1 = right slot
  l_data_o  out  AUDIO_DW  left sample held for the downstream transmitter
  r_data_o  out  AUDIO_DW  right sample held for the downstream transmitter
  underrun_o  out  1  one-cycle pulse when the FIFO is empty at frame start

Function
REQ-005 Divider SHALL count clk_i cycles 0..CLK_DIV-1 while en_i=1; sck_o SHALL toggle at each wrap, giving an sck period of 2*CLK_DIV clk_i cycles.
REQ-006 Bit counter SHALL advance once per sck_o falling edge, modulo 2*SLOT_W.
REQ-007 ws_o SHALL be 0 for bit counts 0..SLOT_W-1 and 1 for bit counts SLOT_W..2*SLOT_W-1; ws_o SHALL change only in the same clk_i cycle as a sck_o falling edge.
REQ-008 Frame start SHALL be defined as the sck_o falling edge at which the bit counter wraps to 0.
REQ-009 FIFO SHALL be 2 stereo entries deep; s_ready_o SHALL equal (count < 2), taken from registered state.
REQ-010 At frame start with FIFO non-empty: pop the oldest entry; l_data_o and r_data_o SHALL update in that same clk_i cycle and hold until the next frame start.
REQ-011 At frame start with FIFO empty: l_data_o and r_data_o SHALL be set to 0; underrun_o SHALL be 1 for exactly that clk_i cycle.
REQ-012 Simultaneous push and pop SHALL leave count unchanged and preserve entry order; a push while full SHALL be ignored.
REQ-013 While en_i=0: divider reset to 0, sck_o=0, ws_o=1, bit counter held at 2*SLOT_W-1, data outputs hold their values, FIFO still accepts pushes.
REQ-014 After en_i rises, the first sck_o rising edge SHALL occur CLK_DIV cycles later and the first falling edge 2*CLK_DIV cycles later; that falling edge is a frame start.
REQ-015 Deasserting en_i mid-frame SHALL force the REQ-013 state on the next clk_i edge, abandoning the frame without a pop.

Reset
REQ-016 While rst_ni=0: sck_o=0, ws_o=1, l_data_o=0, r_data_o=0, underrun_o=0; FIFO empty, so s_ready_o=1; counters held as in REQ-013.
REQ-017 Reset asserted mid-frame SHALL take effect immediately, without waiting for clk_i; FIFO contents SHALL be discarded.

Configuration
REQ-018 With I2S_SRC_UNDERRUN_CNT_EN defined: add output underrun_cnt_o [15:0]; it increments on each underrun_o pulse, saturates at 0xFFFF and is cleared only by reset.
REQ-019 Without I2S_SRC_UNDERRUN_CNT_EN: underrun_cnt_o and its logic SHALL be absent; all other behaviour is unchanged.

Verification (AUDIO_DW=8, CLK_DIV=2, SLOT_W=16)
REQ-020 Release reset, en_i=1 -> sck_o period 4 clk; first sck_o fall and ws_o fall at clk 4; ws_o period 128 clk, high for 64.
REQ-021 Push L=0xA5, R=0x3C before first frame -> l_data_o=0xA5, r_data_o=0x3C from clk 4, held for 128 clk; underrun_o stays 0.
REQ-022 Push 3 frames back to back, no frame start -> first 2 accepted, s_ready_o=0 after the 2nd; 3rd accepted only after next frame-start pop; popped order matches push order.
REQ-023 FIFO empty at frame start -> data outputs 0x00, underrun_o high one cycle; with macro, underrun_cnt_o=1, then 2 at the following empty frame.
REQ-024 en_i dropped at bit count 10 -> next cycle sck_o=0, ws_o=1, no pop; re-enable -> frame start 4 clk later.
REQ-025 rst_ni pulsed low mid-frame with FIFO full -> all REQ-016 values immediately, s_ready_o=1, next frame start underruns.

Source files
------------

// File: rtl/i2s_src.sv
// i2s_src: I2S serial-clock / word-select generator with a 2-entry stereo
// sample FIFO. Each frame start pops one stereo pair onto l_data_o/r_data_o
// for the downstream transmitter. When the FIFO is empty at a frame start,
// the outputs are zeroed and an underrun pulse is raised.
// Optional feature macro: I2S_SRC_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun counter on port underrun_cnt_o.
module i2s_src #(
    parameter int AUDIO_DW = 8,
    parameter int CLK_DIV  = 2,
    parameter int SLOT_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [AUDIO_DW-1:0] s_l_data_i,
    input  logic [AUDIO_DW-1:0] s_r_data_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    output logic                sck_o,
    output logic                ws_o,
    output logic [AUDIO_DW-1:0] l_data_o,
    output logic [AUDIO_DW-1:0] r_data_o,
    output logic                underrun_o
`ifdef I2S_SRC_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_cnt_o
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(SLOT_W);

    // Serial clock timing state
    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;
    logic             ws_q, ws_d;
    logic [BIT_W-1:0] bit_q, bit_d;

    // FIFO control and output state
    logic [1:0]          cnt_q, cnt_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [AUDIO_DW-1:0] l_q, l_d;
    logic [AUDIO_DW-1:0] r_q, r_d;
    logic                und_q, und_d;

    // FIFO storage; contents are only meaningful where cnt_q says so
    logic [AUDIO_DW-1:0] mem_l_q [2];
    logic [AUDIO_DW-1:0] mem_r_q [2];

    logic             div_wrap;
    logic             sck_fall;
    logic             frame_start;
    logic             push;
    logic             pop;
    logic [BIT_W-1:0] bit_inc;

    // Event decode: divider wrap, sck falling edge, frame start, FIFO handshake
    always_comb begin
        div_wrap    = en_i && (div_q == DIV_LAST);
        sck_fall    = div_wrap && sck_q;
        frame_start = sck_fall && (bit_q == BIT_LAST);
        push        = s_valid_i && !cnt_q[1];
        pop         = frame_start && (cnt_q != 2'd0);
        bit_inc     = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
    end

    // Next-state for divider, sck, bit counter and ws; disable parks everything
    // so that the first sck falling edge after enable is a frame start
    always_comb begin
        div_d = div_q;
        sck_d = sck_q;
        bit_d = bit_q;
        ws_d  = ws_q;
        if (!en_i) begin
            div_d = '0;
            sck_d = 1'b0;
            bit_d = BIT_LAST;
            ws_d  = 1'b1;
        end else begin
            div_d = div_wrap ? '0 : div_q + DIV_W'(1);
            if (div_wrap) begin
                sck_d = ~sck_q;
            end
            if (sck_fall) begin
                bit_d = bit_inc;
                ws_d  = (bit_inc >= WS_FIRST);
            end
        end
    end

    // Next-state for FIFO occupancy, pointers and the held output samples
    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        l_d      = l_q;
        r_d      = r_q;
        und_d    = 1'b0;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (frame_start) begin
            if (cnt_q != 2'd0) begin
                l_d = mem_l_q[rd_ptr_q];
                r_d = mem_r_q[rd_ptr_q];
            end else begin
                l_d   = '0;
                r_d   = '0;
                und_d = 1'b1;
            end
        end
    end

    // Timing state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            sck_q <= 1'b0;
            bit_q <= BIT_LAST;
            ws_q  <= 1'b1;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
            bit_q <= bit_d;
            ws_q  <= ws_d;
        end
    end

    // FIFO control and output registers; reset discards any queued frames
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            l_q      <= '0;
            r_q      <= '0;
            und_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            l_q      <= l_d;
            r_q      <= r_d;
            und_q    <= und_d;
        end
    end

    // FIFO storage write on an accepted push
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_l_q[wr_ptr_q] <= s_l_data_i;
            mem_r_q[wr_ptr_q] <= s_r_data_i;
        end
    end

`ifdef I2S_SRC_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Saturating underrun counter, advanced on the same edge that raises the pulse
    always_comb begin
        ucnt_d = ucnt_q;
        if (frame_start && (cnt_q == 2'd0) && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    // Underrun counter register, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ucnt_q <= 16'd0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt_o = ucnt_q;
`endif

    assign s_ready_o  = !cnt_q[1];
    assign sck_o      = sck_q;
    assign ws_o       = ws_q;
    assign l_data_o   = l_q;
    assign r_data_o   = r_q;
    assign underrun_o = und_q;

endmodule

// File: tb/tb_i2s_src.sv
// Directed testbench for i2s_src at AUDIO_DW=8, CLK_DIV=2, SLOT_W=16.
// cyc numbers the clk_i rising edges since the most recent enable/reset
// release; outputs are sampled 1 time unit after each rising edge.
module tb_i2s_src;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] l_in;
    logic [7:0] r_in;
    logic       valid;
    logic       ready;
    logic       sck;
    logic       ws;
    logic [7:0] l_out;
    logic [7:0] r_out;
    logic       und;
`ifdef I2S_SRC_UNDERRUN_CNT_EN
    logic [15:0] ucnt;
`endif

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    i2s_src #(.AUDIO_DW(8), .CLK_DIV(2), .SLOT_W(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .s_l_data_i     (l_in),
        .s_r_data_i     (r_in),
        .s_valid_i      (valid),
        .s_ready_o      (ready),
        .sck_o          (sck),
        .ws_o           (ws),
        .l_data_o       (l_out),
        .r_data_o       (r_out),
        .underrun_o     (und)
`ifdef I2S_SRC_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o (ucnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    int ws_hi;
    int sck_rise;
    int held_bad;
    int ready_hi;
    logic sck_prev;

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        valid = 1'b0;
        l_in  = 8'h00;
        r_in  = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_sck",   sck,   0);
        chk("rst_ws",    ws,    1);
        chk("rst_l",     l_out, 0);
        chk("rst_r",     r_out, 0);
        chk("rst_und",   und,   0);
        chk("rst_ready", ready, 1);

        // Release reset, push one frame while disabled
        rst_n = 1'b1;
        tick();
        valid = 1'b1; l_in = 8'hA5; r_in = 8'h3C;
        tick();
        valid = 1'b0;
        chk("push_dis_ready", ready, 1);
        chk("dis_sck", sck, 0);

        // Enable: first rise at clk 2, first fall/frame start at clk 4
        en  = 1'b1;
        cyc = 0;
        run_to(2);
        chk("first_rise_sck", sck, 1);
        chk("first_rise_ws",  ws,  1);
        run_to(3);
        chk("pre_fs_l", l_out, 8'h00);
        run_to(4);
        chk("fs1_sck", sck,   0);
        chk("fs1_ws",  ws,    0);
        chk("fs1_l",   l_out, 8'hA5);
        chk("fs1_r",   r_out, 8'h3C);
        chk("fs1_und", und,   0);

        // Frame body: clk 5..131
        ws_hi = 0; sck_rise = 0; held_bad = 0; sck_prev = sck;
        while (cyc < 131) begin
            tick();
            if (ws === 1'b1) ws_hi++;
            if (sck === 1'b1 && sck_prev === 1'b0) sck_rise++;
            sck_prev = sck;
            if (l_out !== 8'hA5 || r_out !== 8'h3C || und !== 1'b0) held_bad++;
            if (cyc == 67) chk("ws_before_right", ws, 0);
            if (cyc == 68) chk("ws_right_slot", ws, 1);
        end
        chk("ws_high_cycles", ws_hi, 64);
        chk("sck_rises", sck_rise, 32);
        chk("data_held", held_bad, 0);

        // Empty FIFO at frame start clk 132 -> underrun
        run_to(132);
        chk("ur1_und", und,   1);
        chk("ur1_l",   l_out, 8'h00);
        chk("ur1_r",   r_out, 8'h00);
        chk("ur1_ws",  ws,    0);
`ifdef I2S_SRC_UNDERRUN_CNT_EN
        chk("ur1_cnt", ucnt, 1);
`endif
        run_to(133);
        chk("ur1_pulse_end", und, 0);

        // Three frames back to back; third must wait for a pop
        valid = 1'b1; l_in = 8'h11; r_in = 8'h22;
        chk("f1_ready", ready, 1);
        tick();
        l_in = 8'h33; r_in = 8'h44;
        chk("f2_ready", ready, 1);
        tick();
        l_in = 8'h55; r_in = 8'h66;
        chk("full_ready", ready, 0);
        ready_hi = 0;
        while (cyc < 259) begin
            tick();
            if (ready !== 1'b0) ready_hi++;
        end
        chk("full_ready_held", ready_hi, 0);
        run_to(260);
        chk("pop1_l",     l_out, 8'h11);
        chk("pop1_r",     r_out, 8'h22);
        chk("pop1_und",   und,   0);
        chk("pop1_ready", ready, 1);
        tick();
        valid = 1'b0;
        chk("f3_taken_ready", ready, 0);
        run_to(388);
        chk("pop2_l", l_out, 8'h33);
        chk("pop2_r", r_out, 8'h44);
        run_to(516);
        chk("pop3_l", l_out, 8'h55);
        chk("pop3_r", r_out, 8'h66);
        chk("pop3_ready", ready, 1);
        run_to(643);
        chk("pre_ur2_und", und, 0);
        run_to(644);
        chk("ur2_und", und,   1);
        chk("ur2_l",   l_out, 8'h00);
`ifdef I2S_SRC_UNDERRUN_CNT_EN
        chk("ur2_cnt", ucnt, 2);
`endif

        // Queue one frame, then drop enable at bit count 10 (clk 684)
        run_to(650);
        valid = 1'b1; l_in = 8'h5A; r_in = 8'h69;
        tick();
        valid = 1'b0;
        run_to(684);
        en = 1'b0;
        tick();
        chk("dis_ws",  ws,    1);
        chk("dis_sck0", sck,  0);
        chk("dis_l",   l_out, 8'h00);
        tick();
        chk("dis_sck1", sck, 0);
        run_to(690);
        chk("dis_no_pop_ready", ready, 1);
        chk("dis_l_hold", l_out, 8'h00);
        en = 1'b1;
        run_to(692);
        chk("reen_rise_sck", sck, 1);
        run_to(693);
        chk("reen_pre_ws", ws,    1);
        chk("reen_pre_l",  l_out, 8'h00);
        run_to(694);
        chk("reen_fs_ws",  ws,    0);
        chk("reen_fs_l",   l_out, 8'h5A);
        chk("reen_fs_r",   r_out, 8'h69);
        chk("reen_fs_und", und,   0);

        // Fill FIFO, then pulse reset between clock edges
        valid = 1'b1; l_in = 8'h77; r_in = 8'h88;
        tick();
        l_in = 8'h99; r_in = 8'hAA;
        tick();
        valid = 1'b0;
        chk("pre_rst_full", ready, 0);
        run_to(700);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sck",   sck,   0);
        chk("arst_ws",    ws,    1);
        chk("arst_l",     l_out, 8'h00);
        chk("arst_r",     r_out, 8'h00);
        chk("arst_und",   und,   0);
        chk("arst_ready", ready, 1);
`ifdef I2S_SRC_UNDERRUN_CNT_EN
        chk("arst_cnt", ucnt, 0);
`endif
        #1;
        rst_n = 1'b1;
        cyc = 0;
        run_to(3);
        chk("post_rst_sck", sck, 1);
        chk("post_rst_und", und, 0);
        run_to(4);
        chk("post_rst_ur_und", und,   1);
        chk("post_rst_ur_l",   l_out, 8'h00);
        chk("post_rst_ur_ws",  ws,    0);
        chk("post_rst_ready",  ready, 1);
`ifdef I2S_SRC_UNDERRUN_CNT_EN
        chk("post_rst_cnt", ucnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
